// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolver: update record, resolver FSM states, instruction size.
package branch_resolve_unit_pkg;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] inst_addr;
    } branch_update_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WAIT
    } resolve_state_t;

endpackage

// File: rtl/branch_update_fifo.sv
// Synchronous FIFO of predictor training updates, with a flush-clear input.
// Latency: a push is visible at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module branch_update_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             iCLOCK,
    input  logic             inRESET,
    input  logic             iCLEAR,
    input  logic             iPUSH,
    input  branch_update_t   iPUSH_DATA,
    input  logic             iPOP,
    output branch_update_t   oPOP_DATA,
    output logic             oFULL,
    output logic             oEMPTY,
    output logic [CNT_W-1:0] oCOUNT
);

    branch_update_t   mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign oFULL     = (count == CNT_W'(DEPTH));
    assign oEMPTY    = (count == '0);
    assign oCOUNT    = count;
    assign oPOP_DATA = mem[rdPtr];
    assign doPush    = iPUSH & ~oFULL;
    assign doPop     = iPOP & ~oEMPTY;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (iCLEAR) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= iPUSH_DATA;
                wrPtr      <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves retiring branches against fetch's prediction; mispredicts raise a one-cycle flush, all branches queue predictor updates.
// Latency: flush pulse and earliest update strobe one cycle after accept. BRANCH_RESOLVE_STAT_EN adds branch/miss counters.
// Backpressure: oEXEC_LOCK during flush/wait or with a full update queue; iJUMP_LOCK stalls the drain.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_WAIT = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFLUSH,
    input  logic        iEXEC_VALID,
    input  logic        iEXEC_IS_BRANCH,
    input  logic [31:0] iEXEC_INST_ADDR,
    input  logic        iEXEC_TAKEN,
    input  logic [31:0] iEXEC_TARGET,
    input  logic        iEXEC_PREDICT_BRANCH,
    input  logic [31:0] iEXEC_PREDICT_ADDR,
    output logic        oEXEC_LOCK,
    output logic        oFLUSH_PIPELINE,
    output logic [31:0] oFLUSH_ADDR,
    output logic        oJUMP_STB,
    output logic        oJUMP_HIT,
    output logic [31:0] oJUMP_ADDR,
    output logic [31:0] oJUMP_INST_ADDR,
    input  logic        iJUMP_LOCK
`ifdef BRANCH_RESOLVE_STAT_EN
    ,
    output logic [31:0] oSTAT_BRANCH_COUNT,
    output logic [31:0] oSTAT_MISS_COUNT
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = (FLUSH_WAIT > 1) ? $clog2(FLUSH_WAIT) : 1;

    resolve_state_t    state;
    resolve_state_t    stateNext;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic [31:0]       flushAddr;
    logic [31:0]       correctAddr;
    logic              acceptBranch;
    logic              mispredict;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    branch_update_t    pushData;
    branch_update_t    headData;

    assign acceptBranch = iEXEC_VALID & iEXEC_IS_BRANCH & ~oEXEC_LOCK & ~iFLUSH;
    assign mispredict   = (iEXEC_TAKEN != iEXEC_PREDICT_BRANCH) |
                          (iEXEC_TAKEN & iEXEC_PREDICT_BRANCH & (iEXEC_TARGET != iEXEC_PREDICT_ADDR));
    assign correctAddr  = iEXEC_TAKEN ? iEXEC_TARGET : (iEXEC_INST_ADDR + 32'(INST_BYTES));

    assign pushData.taken     = iEXEC_TAKEN;
    assign pushData.target    = iEXEC_TARGET;
    assign pushData.inst_addr = iEXEC_INST_ADDR;

    branch_update_fifo #(.DEPTH(FIFO_DEPTH)) updateFifo (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .iCLEAR     (iFLUSH),
        .iPUSH      (acceptBranch),
        .iPUSH_DATA (pushData),
        .iPOP       (oJUMP_STB),
        .oPOP_DATA  (headData),
        .oFULL      (fifoFull),
        .oEMPTY     (fifoEmpty),
        .oCOUNT     (fifoCount)
    );

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (acceptBranch && mispredict) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH: begin
                stateNext   = WAIT;
                waitCntNext = WAIT_W'(FLUSH_WAIT - 1);
            end
            WAIT: begin
                if (waitCnt == '0) begin
                    stateNext = IDLE;
                end else begin
                    waitCntNext = waitCnt - WAIT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        // A global flush aborts the sequence; the current FLUSH cycle's pulse still shows this cycle.
        if (iFLUSH) begin
            stateNext   = IDLE;
            waitCntNext = '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state     <= IDLE;
            waitCnt   <= '0;
            flushAddr <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (acceptBranch && mispredict) begin
                flushAddr <= correctAddr;
            end
        end
    end

    assign oEXEC_LOCK      = (state != IDLE) | (fifoCount == CNT_W'(FIFO_DEPTH)) | fifoFull;
    assign oFLUSH_PIPELINE = (state == FLUSH);
    assign oFLUSH_ADDR     = flushAddr;
    assign oJUMP_STB       = ~fifoEmpty & ~iJUMP_LOCK;
    assign oJUMP_HIT       = headData.taken;
    assign oJUMP_ADDR      = headData.target;
    assign oJUMP_INST_ADDR = headData.inst_addr;

`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] branchCount;
    logic [31:0] missCount;

    // Saturating; deliberately untouched by iFLUSH.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            branchCount <= '0;
            missCount   <= '0;
        end else if (acceptBranch) begin
            if (branchCount != 32'hFFFF_FFFF) begin
                branchCount <= branchCount + 32'd1;
            end
            if (mispredict && (missCount != 32'hFFFF_FFFF)) begin
                missCount <= missCount + 32'd1;
            end
        end
    end

    assign oSTAT_BRANCH_COUNT = branchCount;
    assign oSTAT_MISS_COUNT   = missCount;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
